// File: rtl/w_port_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// Optional statistics counters are enabled by defining W_PORT_ARBITER_STATS_EN.
module w_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          w_clk,
    input  logic                          w_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          w_full,
    output logic                          w_inc,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [15:0]                   stat_beats,
    output logic [15:0]                   stat_stalls
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   w_rr_nxt;
    logic [IDW-1:0]   r_grant_id;
    logic [IDW-1:0]   w_gid_nxt;
    logic [IDW-1:0]   w_gid_inc;
    logic [IDW-1:0]   w_sel;
    logic [CW-1:0]    r_burst_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_any_req;
    logic             w_owner_valid;
    logic             w_xfer;
    logic             w_last;
    logic             w_end;

    assign w_any_req = |req_valid;

    // Round-robin pick: first requesting index at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        logic [IDW:0] v_idx;
        logic         v_found;
        w_sel   = r_rr_ptr;
        v_found = 1'b0;
        v_idx   = {(IDW+1){1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (v_idx >= (IDW+1)'(NUM_REQ)) begin
                v_idx = v_idx - (IDW+1)'(NUM_REQ);
            end else begin
                v_idx = v_idx;
            end
            if (!v_found && req_valid[v_idx[IDW-1:0]]) begin
                w_sel   = v_idx[IDW-1:0];
                v_found = 1'b1;
            end else begin
                v_found = v_found;
            end
        end
    end

    // Beat qualification; reset is folded in so a beat presented during reset never counts.
    always_comb begin
        w_owner_valid = req_valid[r_grant_id];
        w_xfer        = w_rst_n && (r_state == ST_BURST) && w_owner_valid && !w_full;
        w_last        = (r_burst_cnt == CW'(MAX_BURST - 1));
        w_end         = (r_state == ST_BURST) && (!w_owner_valid || (w_xfer && w_last));
        if (r_grant_id == IDW'(NUM_REQ - 1)) begin
            w_gid_inc = {IDW{1'b0}};
        end else begin
            w_gid_inc = r_grant_id + IDW'(1);
        end
    end

    // Next-state logic for the IDLE/BURST controller.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_gid_nxt   = r_grant_id;
        w_cnt_nxt   = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_BURST;
                    w_gid_nxt   = w_sel;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (w_end) begin
                    // grant_id is kept so the last owner stays observable while idle
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = w_gid_inc;
                end else if (w_xfer) begin
                    w_cnt_nxt = r_burst_cnt + CW'(1);
                end else begin
                    w_cnt_nxt = r_burst_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= {IDW{1'b0}};
            r_grant_id  <= {IDW{1'b0}};
            r_burst_cnt <= {CW{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_grant_id  <= w_gid_nxt;
            r_burst_cnt <= w_cnt_nxt;
        end
    end

    // Write-port outputs: only the owner's slice and ready bit, only on a real beat.
    always_comb begin
        w_inc     = w_xfer;
        req_ready = {NUM_REQ{1'b0}};
        w_data    = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_xfer && (r_grant_id == IDW'(i))) begin
                req_ready[i] = 1'b1;
                w_data       = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                req_ready[i] = req_ready[i];
            end
        end
    end

    assign busy     = (r_state == ST_BURST);
    assign grant_id = r_grant_id;

`ifdef W_PORT_ARBITER_STATS_EN
    logic        w_stall;
    logic [15:0] r_stat_beats;
    logic [15:0] r_stat_stalls;

    assign w_stall = (r_state == ST_BURST) && w_owner_valid && w_full;

    // Saturating beat and stall counters.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_stat_beats  <= 16'h0000;
            r_stat_stalls <= 16'h0000;
        end else begin
            if (w_xfer && (r_stat_beats != 16'hFFFF)) begin
                r_stat_beats <= r_stat_beats + 16'h0001;
            end else begin
                r_stat_beats <= r_stat_beats;
            end
            if (w_stall && (r_stat_stalls != 16'hFFFF)) begin
                r_stat_stalls <= r_stat_stalls + 16'h0001;
            end else begin
                r_stat_stalls <= r_stat_stalls;
            end
        end
    end

    assign stat_beats  = r_stat_beats;
    assign stat_stalls = r_stat_stalls;
`else
    assign stat_beats  = 16'h0000;
    assign stat_stalls = 16'h0000;
`endif

endmodule

// File: tb/tb_w_port_arbiter.sv
// Bench for w_port_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a grant/beat-count reference model.
module tb_w_port_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;

    logic                          w_clk;
    logic                          w_rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          w_full;
    logic                          w_inc;
    logic [DATA_WIDTH-1:0]         w_data;
    logic [1:0]                    grant_id;
    logic                          busy;
    logic [15:0]                   stat_beats;
    logic [15:0]                   stat_stalls;

    w_port_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .w_clk      (w_clk),
        .w_rst_n    (w_rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .w_full     (w_full),
        .w_inc      (w_inc),
        .w_data     (w_data),
        .grant_id   (grant_id),
        .busy       (busy),
        .stat_beats (stat_beats),
        .stat_stalls(stat_stalls)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: owner, beats taken in this grant, pointer, statistics.
    bit m_busy;
    int m_gid;
    int m_beats;
    int m_rr;
    int m_sb;
    int m_ss;

    int inc_cnt;
    bit prev_busy;
    int grant_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_busy = 1'b0; m_gid = 0; m_beats = 0; m_rr = 0; m_sb = 0; m_ss = 0;
        prev_busy = 1'b0;
    endtask

    task automatic model_edge();
        if (!m_busy) begin
            if (req_valid != '0) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    int c;
                    c = (m_rr + k) % NUM_REQ;
                    if (req_valid[c]) begin
                        m_gid = c;
                        break;
                    end
                end
                m_busy  = 1'b1;
                m_beats = 0;
            end
        end else if (!req_valid[m_gid]) begin
            m_busy = 1'b0;
            m_rr   = (m_gid + 1) % NUM_REQ;
        end else if (w_full) begin
            if (m_ss < 65535) m_ss++;
        end else begin
            m_beats++;
            if (m_sb < 65535) m_sb++;
            if (m_beats == MAX_BURST) begin
                m_busy = 1'b0;
                m_rr   = (m_gid + 1) % NUM_REQ;
            end
        end
    endtask

    task automatic check_model();
        bit                    x;
        logic [NUM_REQ-1:0]    e_rdy;
        logic [DATA_WIDTH-1:0] e_dat;
        x     = m_busy && req_valid[m_gid] && !w_full;
        e_rdy = x ? NUM_REQ'(1 << m_gid) : '0;
        e_dat = x ? req_data[m_gid*DATA_WIDTH +: DATA_WIDTH] : '0;
        chk("m_w_inc", 32'(w_inc), 32'(x));
        chk("m_req_ready", 32'(req_ready), 32'(e_rdy));
        chk("m_w_data", 32'(w_data), 32'(e_dat));
        chk("m_busy", 32'(busy), 32'(m_busy));
        chk("m_grant_id", 32'(grant_id), 32'(m_gid));
`ifdef W_PORT_ARBITER_STATS_EN
        chk("m_stat_beats", 32'(stat_beats), 32'(m_sb));
        chk("m_stat_stalls", 32'(stat_stalls), 32'(m_ss));
`else
        chk("m_stat_off", 32'({stat_beats, stat_stalls}), 32'h0);
`endif
    endtask

    // One cycle: drive at negedge, compare combinational outputs, clock, advance model.
    task automatic step(input logic [NUM_REQ-1:0] v, input logic f);
        @(negedge w_clk);
        req_valid = v;
        w_full    = f;
        req_data  = $urandom;
        #1;
        check_model();
        inc_cnt += int'(w_inc);
        @(posedge w_clk);
        model_edge();
        #1;
        if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
        prev_busy = busy;
    endtask

    task automatic do_reset();
        w_rst_n   = 1'b0;
        req_valid = '0;
        w_full    = 1'b0;
        req_data  = '0;
        model_clear();
        repeat (2) @(posedge w_clk);
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_gid", 32'(grant_id), 32'h0);
        chk("rst_outs", 32'({w_inc, req_ready, w_data}), 32'h0);
        chk("rst_stats", 32'({stat_beats, stat_stalls}), 32'h0);
        @(negedge w_clk);
        w_rst_n = 1'b1;
        inc_cnt = 0;
        grant_log.delete();
    endtask

    initial begin
        int exp_ord[5];
        logic [NUM_REQ-1:0] rv;
        logic rf;
        exp_ord = '{0, 1, 2, 3, 0};
        inc_cnt = 0;

        // Single requester 2: four beats, idle gap, then regranted.
        do_reset();
        step(4'b0100, 1'b0);
        chk("g1_busy", 32'(busy), 32'h1);
        chk("g1_gid", 32'(grant_id), 32'h2);
        repeat (4) step(4'b0100, 1'b0);
        chk("g1_beats", 32'(inc_cnt), 32'h4);
        chk("g1_idle", 32'(busy), 32'h0);
        chk("g1_gid_held", 32'(grant_id), 32'h2);
        step(4'b0100, 1'b0);
        chk("g1_regrant", 32'({busy, grant_id}), 32'h6);

        // All requesting: round-robin order and full-length bursts.
        do_reset();
        repeat (25) step(4'b1111, 1'b0);
        chk("rr_count", 32'(grant_log.size()), 32'h5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) chk("rr_order", 32'(grant_log[i]), 32'(exp_ord[i]));
        end
        chk("rr_beats", 32'(inc_cnt), 32'd20);
`ifdef W_PORT_ARBITER_STATS_EN
        chk("rr_stat_beats", 32'(stat_beats), 32'd20);
`endif

        // Stall of three cycles mid-burst for requester 1.
        do_reset();
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        repeat (3) step(4'b0010, 1'b1);
        chk("st_beats_held", 32'(inc_cnt), 32'h1);
        chk("st_busy", 32'({busy, grant_id}), 32'h5);
`ifdef W_PORT_ARBITER_STATS_EN
        chk("st_stat_stalls", 32'(stat_stalls), 32'h3);
`endif
        repeat (3) step(4'b0010, 1'b0);
        chk("st_done_beats", 32'(inc_cnt), 32'h4);
        chk("st_done_idle", 32'(busy), 32'h0);

        // Requester 0 drops after two beats; requester 1 takes over.
        do_reset();
        step(4'b0011, 1'b0);
        step(4'b0011, 1'b0);
        step(4'b0011, 1'b0);
        step(4'b0010, 1'b0);
        chk("dr_end", 32'(busy), 32'h0);
        step(4'b0010, 1'b0);
        chk("dr_beats", 32'(inc_cnt), 32'h2);
        chk("dr_next", 32'({busy, grant_id}), 32'h5);

        // Reset pulse during the second beat.
        do_reset();
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        @(negedge w_clk);
        req_valid = 4'b0001;
        w_full    = 1'b0;
        #1;
        chk("ab_beat2", 32'(w_inc), 32'h1);
        w_rst_n = 1'b0;
        #1;
        chk("ab_outs", 32'({w_inc, req_ready, w_data, busy}), 32'h0);
        chk("ab_stats", 32'({stat_beats, stat_stalls}), 32'h0);
        model_clear();
        @(posedge w_clk);
        @(negedge w_clk);
        req_valid = '0;
        w_rst_n   = 1'b1;
        step(4'b1000, 1'b0);
        chk("ab_regrant", 32'({busy, grant_id}), 32'h7);

        // Randomized traffic with sticky request patterns and random back-pressure.
        rv = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) rv = 4'($urandom_range(0, 15));
            rf = ($urandom_range(0, 9) < 3);
            step(rv, rf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/w_port_arbiter.md
W_PORT_ARBITER -- requirements
Module: w_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing the FIFO write port (range 2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the FIFO write-data width.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, meaning the maximum beats per grant (range 1..16).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports w_clk and w_rst_n.
REQ-005 w_clk  in  1  write-domain clock; all state on rising edge.
REQ-006 w_rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  NUM_REQ  per-requester write request; bit i belongs to requester i.
REQ-008 req_data  in  NUM_REQ*DATA_WIDTH  requester i data in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_ready  out  NUM_REQ  per-requester beat acceptance, one-hot or zero.
REQ-010 w_full  in  1  full flag from the write-pointer block (combinational, current state).
REQ-011 w_inc  out  1  write strobe to the write-pointer block and FIFO memory.
REQ-012 w_data  out  DATA_WIDTH  data of the granted requester.
REQ-013 grant_id  out  $clog2(NUM_REQ)  index of the current owner, valid while busy=1.
REQ-014 busy  out  1  high while in state BURST.
REQ-015 stat_beats  out  16  saturating count of accepted beats (Configuration).
REQ-016 stat_stalls  out  16  saturating count of full-stall cycles (Configuration).

Function
REQ-017 The FSM SHALL have two states: IDLE and BURST.
REQ-018 In IDLE with any req_valid bit set, the block SHALL select the first set bit at or after rr_ptr (modulo NUM_REQ), register it as grant_id, clear burst_cnt and enter BURST on the next edge; no beat transfers in IDLE.
REQ-019 In BURST a beat SHALL transfer when req_valid[grant_id]=1 and w_full=0: w_inc=1, req_ready[grant_id]=1, w_data=req slice grant_id, all combinational in the same cycle.
REQ-020 w_inc and every req_ready bit SHALL be 0 whenever w_full=1, in IDLE, and for non-granted requesters.
REQ-021 burst_cnt SHALL increment on each transfer; a transfer with burst_cnt=MAX_BURST-1 SHALL end the grant.
REQ-022 The grant SHALL also end when req_valid[grant_id]=0 in BURST (no transfer that cycle).
REQ-023 w_full=1 with req_valid[grant_id]=1 SHALL stall: state, grant_id and burst_cnt held.
REQ-024 On grant end the block SHALL set rr_ptr=(grant_id+1) mod NUM_REQ and return to IDLE; minimum grant-to-grant gap is one IDLE cycle.
REQ-025 w_data SHALL be 0 when no transfer occurs.
REQ-026 Changes to req_valid of non-granted requesters during BURST SHALL not affect the current grant.

Reset
REQ-027 While w_rst_n=0 the block SHALL force state IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, busy=0, w_inc=0, req_ready=0, w_data=0, stat_beats=0, stat_stalls=0.
REQ-028 Reset asserted mid-burst SHALL abort the burst immediately; a beat combinationally presented that cycle SHALL not be counted as transferred.
REQ-029 After reset release the first grant SHALL follow REQ-018 with rr_ptr=0.

Configuration
REQ-030 Macro W_PORT_ARBITER_STATS_EN defined: stat_beats SHALL increment per transfer and stat_stalls per BURST cycle with req_valid[grant_id]=1 and w_full=1, both saturating at 16'hFFFF.
REQ-031 Macro undefined: stat_beats and stat_stalls SHALL be tied to 0, no counter registers instantiated; all other behaviour identical.

Verification
REQ-032 Reset, req_valid=4'b0100, w_full=0 -> busy=1 next cycle with grant_id=2; 4 beats with w_inc=1; IDLE; grant_id=2 again, rr_ptr=3.
REQ-033 req_valid=4'b1111 held, w_full=0 -> grant order 0,1,2,3,0; each grant exactly 4 beats; stat_beats=20 after 5 grants (STATS_EN).
REQ-034 Granted requester 1 with w_full=1 for 3 cycles mid-burst -> w_inc=0, req_ready=0, burst_cnt held; stat_stalls=3; burst completes after w_full drops.
REQ-035 Granted requester 0 drops req_valid after 2 beats -> grant ends with no third beat; next grant goes to requester 1 if requesting.
REQ-036 w_rst_n pulsed low during beat 2 of a burst -> all outputs 0 same cycle; after release, req_valid=4'b1000 -> grant_id=3.
